// File: rtl/irq_controller.sv
// Prioritised, nesting interrupt controller with per-line synchronizer and debounce.
// Ports: clk, rst (async active-low); IRQ raw lines in; int_ack/int_eret from CPU;
//   int_req/int_id request out; IRW in-service flags; pending latched requests.
module irq_controller #(
   parameter int N_IRQ       = 3,
   parameter int SYNC_STAGES = 2,
   parameter int DB_CYCLES   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_IRQ-1:0] IRQ,
   input  logic             int_ack,
   input  logic             int_eret,
   output logic             int_req,
   output logic [1:0]       int_id,
   output logic [N_IRQ-1:0] IRW,
   output logic [N_IRQ-1:0] pending
);

   localparam int CW = $clog2(DB_CYCLES + 1);
   localparam int IW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

   logic [N_IRQ-1:0] sync_q [SYNC_STAGES];
   logic [N_IRQ-1:0] lvl;

   logic [CW-1:0]    cnt_q [N_IRQ];
   logic [CW-1:0]    cnt_d [N_IRQ];
   logic [N_IRQ-1:0] filt_q, filt_d;
   logic [N_IRQ-1:0] filt_dly_q;
   logic [N_IRQ-1:0] rise;

   logic [N_IRQ-1:0] pend_q, pend_d;
   logic [N_IRQ-1:0] irw_q, irw_d;
   logic [N_IRQ-1:0] irw_e;

   logic             p_vld, s_vld, s2_vld;
   logic [IW-1:0]    p_idx, s_idx, s2_idx;
   logic             req2;

   // Input synchronizer
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      end else begin
         sync_q[0] <= IRQ;
         for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      end
   end

   assign lvl = sync_q[SYNC_STAGES-1];

   // Debounce: accept a new level on the DB_CYCLES-th consecutive differing clock
   always_comb begin
      filt_d = filt_q;
      for (int i = 0; i < N_IRQ; i++) begin
         cnt_d[i] = '0;
         if (lvl[i] != filt_q[i]) begin
            if (cnt_q[i] == CW'(DB_CYCLES - 1)) filt_d[i] = lvl[i];
            else cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end
   end

   // Rising edge of the filtered level, seen one clock after it rises
   assign rise = filt_q & ~filt_dly_q;

   // Highest pending and highest in-service line
   always_comb begin
      p_vld = 1'b0;
      p_idx = '0;
      s_vld = 1'b0;
      s_idx = '0;
      for (int i = 0; i < N_IRQ; i++) begin
         if (pend_q[i]) begin
            p_vld = 1'b1;
            p_idx = IW'(i);
         end
         if (irw_q[i]) begin
            s_vld = 1'b1;
            s_idx = IW'(i);
         end
      end
   end

   assign int_req = p_vld && (!s_vld || (p_idx > s_idx));
   assign int_id  = int_req ? (2'(p_idx) + 2'd1) : 2'd0;

   // eret retires first; the ack decision uses the post-eret in-service set
   always_comb begin
      irw_e = irw_q;
      if (int_eret && s_vld) irw_e[s_idx] = 1'b0;

      s2_vld = 1'b0;
      s2_idx = '0;
      for (int i = 0; i < N_IRQ; i++) begin
         if (irw_e[i]) begin
            s2_vld = 1'b1;
            s2_idx = IW'(i);
         end
      end
      req2 = p_vld && (!s2_vld || (p_idx > s2_idx));

      irw_d  = irw_e;
      pend_d = pend_q;
      if (int_ack && req2) begin
         pend_d[p_idx] = 1'b0;
         irw_d[p_idx]  = 1'b1;
      end
      // A fresh edge wins over a same-cycle ack clear
      pend_d = pend_d | rise;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N_IRQ; i++) cnt_q[i] <= '0;
         filt_q     <= '0;
         filt_dly_q <= '0;
         pend_q     <= '0;
         irw_q      <= '0;
      end else begin
         for (int i = 0; i < N_IRQ; i++) cnt_q[i] <= cnt_d[i];
         filt_q     <= filt_d;
         filt_dly_q <= filt_q;
         pend_q     <= pend_d;
         irw_q      <= irw_d;
      end
   end

   assign IRW     = irw_q;
   assign pending = pend_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller with hand-computed expectations.
// Drives and samples on the falling clock edge.
module tb_irq_controller;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [2:0] IRQ = 3'b000;
   logic       int_ack = 1'b0;
   logic       int_eret = 1'b0;
   logic       int_req;
   logic [1:0] int_id;
   logic [2:0] IRW;
   logic [2:0] pending;

   int total = 0;
   int bad   = 0;

   irq_controller dut (
      .clk      (clk),
      .rst      (rst),
      .IRQ      (IRQ),
      .int_ack  (int_ack),
      .int_eret (int_eret),
      .int_req  (int_req),
      .int_id   (int_id),
      .IRW      (IRW),
      .pending  (pending)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic er,
                          input logic [1:0] eid, input logic [2:0] eirw,
                          input logic [2:0] ep);
      chk({tag, ".req"}, 32'(int_req), 32'(er));
      chk({tag, ".id"},  32'(int_id),  32'(eid));
      chk({tag, ".irw"}, 32'(IRW),     32'(eirw));
      chk({tag, ".pend"}, 32'(pending), 32'(ep));
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_ack();
      int_ack = 1'b1;
      tick(1);
      int_ack = 1'b0;
   endtask

   task automatic do_eret();
      int_eret = 1'b1;
      tick(1);
      int_eret = 1'b0;
   endtask

   initial begin
      // Reset with line 0 already high
      IRQ = 3'b001;
      #3;
      chk_out("rst0", 1'b0, 2'd0, 3'b000, 3'b000);
      tick(3);
      chk_out("rst1", 1'b0, 2'd0, 3'b000, 3'b000);
      rst = 1'b1;

      // Held line: pending appears after the 7th edge (E0+6)
      tick(6);
      chk("lat.early", 32'(pending), 32'h0);
      tick(1);
      chk_out("lat", 1'b1, 2'd1, 3'b000, 3'b001);

      // Ack line 0, then nest line 2 over it
      do_ack();
      chk_out("ack0", 1'b0, 2'd0, 3'b001, 3'b000);
      IRQ[2] = 1'b1;
      tick(7);
      chk_out("pre2", 1'b1, 2'd3, 3'b001, 3'b100);
      do_ack();
      chk_out("ack2", 1'b0, 2'd0, 3'b101, 3'b000);
      IRQ[2] = 1'b0;
      do_eret();
      chk("eret1.irw", 32'(IRW), 32'h1);
      do_eret();
      chk("eret2.irw", 32'(IRW), 32'h0);

      // Short pulse rejected, minimum pulse accepted
      IRQ[1] = 1'b1;
      tick(3);
      IRQ[1] = 1'b0;
      tick(10);
      chk("pulse3.pend", 32'(pending), 32'h0);
      IRQ[1] = 1'b1;
      tick(4);
      IRQ[1] = 1'b0;
      tick(10);
      chk_out("pulse4", 1'b1, 2'd2, 3'b000, 3'b010);
      do_ack();
      do_eret();
      chk_out("clr1", 1'b0, 2'd0, 3'b000, 3'b000);

      // Line 2 in service masks lower pending line 0
      IRQ[2] = 1'b1;
      tick(7);
      do_ack();
      IRQ[2] = 1'b0;
      IRQ[0] = 1'b0;
      tick(10);
      IRQ[0] = 1'b1;
      tick(10);
      chk_out("mask", 1'b0, 2'd0, 3'b100, 3'b001);
      do_eret();
      chk_out("unmask", 1'b1, 2'd1, 3'b000, 3'b001);

      // Ignored ack and ignored eret
      do_ack();
      chk_out("ack0b", 1'b0, 2'd0, 3'b001, 3'b000);
      do_ack();
      chk_out("ackign", 1'b0, 2'd0, 3'b001, 3'b000);
      do_eret();
      do_eret();
      chk_out("eretign", 1'b0, 2'd0, 3'b000, 3'b000);

      // Async reset mid-ISR: IRW=010, pending=001
      IRQ[1] = 1'b1;
      tick(7);
      do_ack();
      IRQ[1] = 1'b0;
      IRQ[0] = 1'b0;
      tick(10);
      IRQ[0] = 1'b1;
      tick(10);
      chk_out("preRst", 1'b0, 2'd0, 3'b010, 3'b001);
      IRQ = 3'b000;
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk_out("asyncRst", 1'b0, 2'd0, 3'b000, 3'b000);
      @(negedge clk);
      rst = 1'b1;
      tick(15);
      chk_out("postRst", 1'b0, 2'd0, 3'b000, 3'b000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 The block SHALL have parameter N_IRQ, default 3, meaning the number of interrupt lines; line index N_IRQ-1 has the highest priority.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, meaning the flop depth of the input synchronizer (minimum 2).
REQ-003 The block SHALL have parameter DB_CYCLES, default 4, meaning the number of consecutive clocks a synchronized level must persist before it is accepted (minimum 1).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port IRQ, input, N_IRQ bits: raw asynchronous button lines, active-high.
REQ-007 The block SHALL have port int_ack, input, 1 bit: one-clock pulse from the CPU when it enters the ISR for int_id.
REQ-008 The block SHALL have port int_eret, input, 1 bit: one-clock pulse from the CPU on ISR return.
REQ-009 The block SHALL have port int_req, output, 1 bit: interrupt request to the CPU.
REQ-010 The block SHALL have port int_id, output, 2 bits: requested line index plus 1; 0 means none.
REQ-011 The block SHALL have port IRW, output, N_IRQ bits: in-service flags, one per line, for LEDs.
REQ-012 The block SHALL have port pending, output, N_IRQ bits: latched, not-yet-acknowledged requests.

Function
REQ-013 Each IRQ bit SHALL pass through a SYNC_STAGES-deep flop chain before any other use.
REQ-014 Each line SHALL have a debounce counter plus a filtered level: the counter clears on any clock where the synchronized level equals the filtered level, and otherwise increments.
REQ-015 When a line has differed for DB_CYCLES consecutive clocks, its filtered level SHALL take the synchronized value on that edge; pulses shorter than DB_CYCLES clocks SHALL be rejected.
REQ-016 A 0-to-1 transition of a filtered level SHALL set the corresponding pending bit on the next edge; 1-to-0 transitions SHALL have no effect.
REQ-017 If IRQ rises before edge E0 and then holds, the pending bit SHALL be high after edge E0+SYNC_STAGES+DB_CYCLES (E0+6 with defaults).
REQ-018 Let P be the highest set pending index and S the highest set IRW index (each -1 if none); int_req SHALL be combinational and equal (P > S).
REQ-019 When int_req=1, int_id SHALL equal P+1; otherwise int_id SHALL be 0.
REQ-020 If int_ack=1 while int_req=1, the block SHALL clear pending[P] and set IRW[P] on the same edge; this nests, so a higher line preempts a lower in-service line.
REQ-021 If int_ack=1 while int_req=0, the pulse SHALL be ignored.
REQ-022 If int_eret=1, the block SHALL clear IRW[S]; if no IRW bit is set, the pulse SHALL be ignored.
REQ-023 If int_eret and int_ack occur in the same cycle, the eret clear SHALL apply first; P and S SHALL then be re-evaluated on the post-eret IRW before the ack set.
REQ-024 If a new edge on line i and an ack clearing pending[i] occur in the same cycle, pending[i] SHALL remain 1.
REQ-025 An edge on a line whose IRW bit is already set SHALL still set its pending bit; that request SHALL be served after the matching eret.

Reset
REQ-026 While rst=0, the block SHALL clear all synchronizer flops, debounce counters, filtered levels, pending bits and IRW bits, regardless of clk.
REQ-027 Outputs during reset SHALL be: int_req=0, int_id=0, IRW=0, pending=0.
REQ-028 A line held high through reset release SHALL produce one pending edge once its filtered level rises (REQ-017 timing, measured from release).
REQ-029 Reset asserted mid-debounce or mid-ISR SHALL discard all state with no residual request.

Verification
REQ-030 The bench SHALL hold IRQ[0]=1 from before edge E0 -> pending=001, int_req=1, int_id=1 after edge E0+6.
REQ-031 The bench SHALL apply a 3-clock pulse on IRQ[1], then a 4-clock pulse -> first: pending stays 000; second: pending=010 and int_id=2.
REQ-032 The bench SHALL set pending=001, ack, then raise IRQ[2] and ack again -> IRW 001 then 101, int_id=3 before the second ack; one eret -> IRW=001; a second eret -> IRW=000.
REQ-033 The bench SHALL hold IRW=100 with line 0 pending -> int_req=0; after eret, int_req=1 and int_id=1.
REQ-034 The bench SHALL pulse int_ack with int_req=0 -> no state change; pulse int_eret with IRW=000 -> no state change.
REQ-035 The bench SHALL drop rst asynchronously mid-ISR with IRW=010 and pending=001 -> all outputs read 0 before the next clk edge.
